systolic_sequencer: RTL and testbench

Controller that runs one M×M matrix multiply, C = A·B, on the `systolic_array` datapath. On `start` it clears the array accumulators and reads A column-by-column and B row-by-row from external operand buffers. It skews the operands into the array's `x_in`/`y_in` edges, holds the array enable for exactly the compute window, and then flags the `acc_sum` results valid. It sits between the operand buffers/host and one `systolic_array` instance, and drives that instance's `rst` and `en` pins.

---
 rtl/systolic_sequencer.sv | 139 +++++++++++++
 tb/tb_systolic_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Sequencer for one MxM systolic matrix multiply: clears the array, streams A columns
// and B rows out of the operand buffers with diagonal skew, then flags the result valid.
module systolic_sequencer #(
  parameter int N = 32,
  parameter int M = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 acc_valid,
  output logic                 rd_en,
  output logic [$clog2(M)-1:0] rd_addr,
  input  logic [N-1:0]         a_rd_data [0:M-1],
  input  logic [N-1:0]         b_rd_data [0:M-1],
  output logic                 arr_clr,
  output logic                 arr_en,
  output logic signed [N-1:0]  arr_x [0:M-1],
  output logic signed [N-1:0]  arr_y [0:M-1]
);

  localparam int AW = $clog2(M);
  localparam int TW = $clog2(3 * M - 2);
  localparam logic [TW-1:0] T_RD   = TW'(M - 1);
  localparam logic [TW-1:0] T_LAST = TW'(3 * M - 3);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic          acc_valid_q;
  logic          rd_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      t           <= '0;
      acc_valid_q <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      t        <= t_nxt;
      rd_valid <= rd_en;
      if (state == IDLE && start)
        acc_valid_q <= 1'b0;
      else if (state == FEED && t == T_LAST)
        acc_valid_q <= 1'b1;
    end
  end

  // Outputs are forced to their idle values while rst is low, so the array clears with us.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    arr_en    = 1'b0;
    arr_clr   = !rst;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy      = 1'b1;
        arr_clr   = 1'b1;
        rd_en     = 1'b1;
        t_nxt     = '0;
        state_nxt = FEED;
      end
      FEED: begin
        busy   = 1'b1;
        arr_en = 1'b1;
        if (t < T_RD) begin
          rd_en   = 1'b1;
          rd_addr = AW'(t + TW'(1));
        end
        if (t == T_LAST) begin
          t_nxt     = '0;
          state_nxt = DONE;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      busy    = 1'b0;
      done    = 1'b0;
      rd_en   = 1'b0;
      rd_addr = '0;
      arr_en  = 1'b0;
    end
  end

  assign acc_valid = acc_valid_q && rst;

  // Lane g is delayed g registers; a valid bit rides with each stage so empty slots read 0.
  for (genvar g = 0; g < M; g++) begin : g_lane
    if (g == 0) begin : g_direct
      assign arr_x[0] = (rd_valid && rst) ? a_rd_data[0] : '0;
      assign arr_y[0] = (rd_valid && rst) ? b_rd_data[0] : '0;
    end else begin : g_skew
      logic [N-1:0] xd [0:g-1];
      logic [N-1:0] yd [0:g-1];
      logic         vd [0:g-1];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int d = 0; d < g; d++) begin
            xd[d] <= '0;
            yd[d] <= '0;
            vd[d] <= 1'b0;
          end
        end else begin
          xd[0] <= a_rd_data[g];
          yd[0] <= b_rd_data[g];
          vd[0] <= rd_valid;
          for (int d = 1; d < g; d++) begin
            xd[d] <= xd[d-1];
            yd[d] <= yd[d-1];
            vd[d] <= vd[d-1];
          end
        end
      end

      assign arr_x[g] = (vd[g-1] && rst) ? xd[g-1] : '0;
      assign arr_y[g] = (vd[g-1] && rst) ? yd[g-1] : '0;
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer (M=4): behavioural operand buffers and a
// behavioural output-stationary systolic array check sequencing, skew and results.
module tb_systolic_sequencer;

  localparam int N = 32;
  localparam int M = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic                busy;
  logic                done;
  logic                acc_valid;
  logic                rd_en;
  logic [1:0]          rd_addr;
  logic [N-1:0]        a_rd_data [0:M-1];
  logic [N-1:0]        b_rd_data [0:M-1];
  logic                arr_clr;
  logic                arr_en;
  logic signed [N-1:0] arr_x [0:M-1];
  logic signed [N-1:0] arr_y [0:M-1];

  int amat [0:M-1][0:M-1];
  int bmat [0:M-1][0:M-1];
  int expc [0:M-1][0:M-1];

  logic signed [N-1:0] acc [0:M-1][0:M-1];
  logic signed [N-1:0] xr  [0:M-1][0:M-1];
  logic signed [N-1:0] yr  [0:M-1][0:M-1];

  int checks;
  int errors;
  int done_count;

  systolic_sequencer #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .acc_valid (acc_valid),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_rd_data (a_rd_data),
    .b_rd_data (b_rd_data),
    .arr_clr   (arr_clr),
    .arr_en    (arr_en),
    .arr_x     (arr_x),
    .arr_y     (arr_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers: one-cycle read latency, data held (stale) when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < M; i++) begin
        a_rd_data[i] <= amat[i][rd_addr];
        b_rd_data[i] <= bmat[rd_addr][i];
      end
    end
  end

  // Output-stationary array: x flows right, y flows down, each PE accumulates x*y.
  always @(posedge clk) begin : array_model
    logic signed [N-1:0] xv;
    logic signed [N-1:0] yv;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        if (j == 0) xv = arr_x[i]; else xv = xr[i][j-1];
        if (i == 0) yv = arr_y[j]; else yv = yr[i-1][j];
        if (arr_clr) begin
          acc[i][j] <= '0;
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
        end else if (arr_en) begin
          acc[i][j] <= acc[i][j] + xv * yv;
          xr[i][j]  <= xv;
          yr[i][j]  <= yv;
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAcc(input string name);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        checkOutput($sformatf("%s_acc%0d%0d", name, i, j), acc[i][j], expc[i][j]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        amat[i][k] = (i == k) ? 1 : 0;
        bmat[i][k] = 4 * i + k + 1;
      end

    $display("[TB] reset");
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_acc_valid", acc_valid, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_arr_en", arr_en, 0);
    checkOutput("rst_arr_clr", arr_clr, 1);
    for (int i = 0; i < M; i++) begin
      checkOutput($sformatf("rst_arr_x%0d", i), arr_x[i], 0);
      checkOutput($sformatf("rst_arr_y%0d", i), arr_y[i], 0);
    end
    applyStimulus(0, 1);
    checkOutput("rel_arr_clr", arr_clr, 0);
    checkOutput("rel_busy", busy, 0);
    applyStimulus(0, 1);

    $display("[TB] identity multiply");
    applyStimulus(1, 1);
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("id_busy_c%0d", c), busy, 1);
      checkOutput($sformatf("id_done_c%0d", c), done, (c == 12));
      checkOutput($sformatf("id_arr_en_c%0d", c), arr_en, (c >= 2 && c <= 11));
      checkOutput($sformatf("id_arr_clr_c%0d", c), arr_clr, (c == 1));
      checkOutput($sformatf("id_rd_en_c%0d", c), rd_en, (c <= 4));
      checkOutput($sformatf("id_acc_valid_c%0d", c), acc_valid, (c == 12));
      if (c <= 4) checkOutput($sformatf("id_rd_addr_c%0d", c), rd_addr, c - 1);
      if (c < 12) applyStimulus(0, 1);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) expc[i][j] = 4 * i + j + 1;
    checkAcc("id");
    applyStimulus(0, 1);
    checkOutput("id_busy_after", busy, 0);
    checkOutput("id_done_after", done, 0);
    checkOutput("id_acc_valid_after", acc_valid, 1);

    $display("[TB] skew");
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        amat[i][k] = 10 * i + k;
        bmat[i][k] = 1;
      end
    applyStimulus(1, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2 && c <= 11) begin
        checkOutput($sformatf("sk_x3_t%0d", c - 2), arr_x[3],
                    (c - 2 >= 3 && c - 2 <= 6) ? 30 + (c - 2) - 3 : 0);
        checkOutput($sformatf("sk_y3_t%0d", c - 2), arr_y[3], (c - 2 >= 3 && c - 2 <= 6) ? 1 : 0);
      end
      if (c == 3) checkOutput("sk_x0_t1", arr_x[0], 1);
      if (c == 6) begin
        checkOutput("sk_x0_t4", arr_x[0], 0);
        checkOutput("sk_x1_t4", arr_x[1], 13);
      end
      if (c < 12) applyStimulus(0, 1);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) expc[i][j] = 40 * i + 6;
    checkAcc("sk");
    applyStimulus(0, 1);

    $display("[TB] signed values with start re-pulsed while busy");
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        amat[i][k] = 0;
        bmat[i][k] = 0;
      end
    amat[0][0] = -1; amat[0][1] = 2; amat[1][0] = 3; amat[1][1] = -4; amat[3][3] = -3;
    bmat[0][0] = 5;  bmat[0][1] = -6; bmat[1][0] = -7; bmat[1][1] = 8; bmat[3][3] = 7;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) expc[i][j] = 0;
    expc[0][0] = -19; expc[0][1] = 22; expc[1][0] = 43; expc[1][1] = -50; expc[3][3] = -21;
    done_count = 0;
    applyStimulus(1, 1);
    for (int c = 1; c <= 24; c++) begin
      if (done) done_count++;
      if (c == 12) checkAcc("sg");
      if (c == 13 || c == 14) checkOutput($sformatf("sg_busy_c%0d", c), busy, 0);
      applyStimulus((c == 4 || c == 12), 1);
    end
    checkOutput("sg_done_count", done_count, 1);

    $display("[TB] abort by reset in FEED");
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        amat[i][k] = (i == k) ? 1 : 0;
        bmat[i][k] = 4 * i + k + 1;
      end
    applyStimulus(1, 1);
    repeat (4) applyStimulus(0, 1);
    checkOutput("ab_arr_en_t3", arr_en, 1);
    applyStimulus(0, 0);
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_arr_en", arr_en, 0);
    checkOutput("ab_arr_clr", arr_clr, 1);
    checkOutput("ab_done", done, 0);
    checkOutput("ab_rd_en", rd_en, 0);
    checkOutput("ab_arr_x0", arr_x[0], 0);
    checkOutput("ab_acc_valid", acc_valid, 0);
    done_count = 0;
    for (int c = 0; c < 15; c++) begin
      applyStimulus(0, 1);
      if (done) done_count++;
    end
    checkOutput("ab_done_count", done_count, 0);
    checkOutput("ab_busy_idle", busy, 0);
    applyStimulus(1, 1);
    repeat (11) applyStimulus(0, 1);
    checkOutput("ab_rerun_done", done, 1);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) expc[i][j] = 4 * i + j + 1;
    checkAcc("ab");

    $display("[TB] back-to-back");
    applyStimulus(0, 1);
    checkOutput("bb_acc_valid_idle", acc_valid, 1);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        amat[i][k] = 10 * i + k;
        bmat[i][k] = 2;
      end
    applyStimulus(1, 1);
    checkOutput("bb_acc_valid_clear", acc_valid, 0);
    checkOutput("bb_arr_clr", arr_clr, 1);
    checkOutput("bb_busy", busy, 1);
    applyStimulus(0, 1);
    checkOutput("bb_acc00_cleared", acc[0][0], 0);
    repeat (10) applyStimulus(0, 1);
    checkOutput("bb_done", done, 1);
    checkOutput("bb_acc_valid_done", acc_valid, 1);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) expc[i][j] = 80 * i + 12;
    checkAcc("bb");
    applyStimulus(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
